pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Drives PC/nPC and IF/ID load enables and the control-mux select `S` (1 = pass decoded control, 0 = inject all-zero NOP).
- Generates EX-stage forwarding selects.
- Owns a start-up fill sequence, load-use interlock, and a multi-cycle HI/LO (mult/div) busy tracker with structural-hazard stalls.

Parameters:
- INIT_CYCLES, 4, cycles after reset during which NOPs are injected while fetch advances.
- MULDIV_LAT, 8, cycles HI/LO unit stays busy after an accepted mult/div.
- STALL_CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  ID-stage source register rs.
- id_rt  in  5  ID-stage source register rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- id_muldiv_start  in  1  ID instruction is mult/multu/div/divu.
- ex_rd  in  5  EX destination register.
- ex_rf_enable  in  1  EX writes register file.
- ex_load_instr  in  1  EX is a load.
- mem_rd  in  5  MEM destination register.
- mem_rf_enable  in  1  MEM writes register file.
- wb_rd  in  5  WB destination register.
- wb_rf_enable  in  1  WB writes register file.
- le_pc  out  1  PC load enable.
- le_npc  out  1  nPC load enable.
- le_if_id  out  1  IF/ID register load enable.
- S  out  1  control-mux select: 1 = pass control, 0 = NOP.
- fwd_a  out  2  rs operand select: 00 RF, 01 EX, 10 MEM, 11 WB.
- fwd_b  out  2  rt operand select, same encoding.
- muldiv_busy  out  1  HI/LO unit busy.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- While reset is high, all outputs are forced to these values: le_pc=le_npc=le_if_id=0, S=0, fwd_a=fwd_b=00, muldiv_busy=0, stall_count=0.
- On the reset edge: FSM enters INIT with init_cnt=INIT_CYCLES-1; muldiv counter is cleared.
- Reset asserted mid-operation aborts everything, including a busy mult/div, and behaves identically.
- Outputs le_*, S, fwd_* are combinational from current inputs and registered state; muldiv_busy and stall_count are registered.
- FSM state INIT:
  - le_pc=le_npc=le_if_id=1, S=0.
  - Hazards are ignored; id_muldiv_start is not accepted; stall_count is not incremented.
  - init_cnt decrements each cycle; the cycle with init_cnt==0 is the last INIT cycle, then the FSM goes to RUN.
  - With INIT_CYCLES=4, S=0 for exactly 4 cycles after reset deasserts.
- FSM state RUN, stall conditions:
  - load_use = ex_load_instr & ex_rf_enable & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - hilo_haz = muldiv_busy & (id_reads_hilo | id_muldiv_start).
  - stall = load_use | hilo_haz.
- RUN outputs:
  - If stall: le_pc=le_npc=le_if_id=0, S=0.
  - Else: all enables=1, S=1.
- Concurrent load_use and hilo_haz produce a single stall cycle; stall_count increments by 1.
- stall_count increments on every RUN cycle with stall=1 and saturates at all-ones.
- Mult/div acceptance:
  - id_muldiv_start is accepted in RUN when stall=0.
  - On the accepting edge the muldiv counter loads MULDIV_LAT and muldiv_busy=1.
  - The counter decrements each cycle; muldiv_busy = (cnt!=0). Busy therefore holds for exactly MULDIV_LAT cycles after acceptance.
  - A start presented in the final busy cycle stalls and is accepted on the next cycle.
- Forwarding (valid in all states):
  - For each operand, the first match in priority order EX, then MEM, then WB is selected.
  - A stage matches when its rf_enable=1, its rd!=0 and rd equals the operand register.
  - If no stage matches, select 00.
  - Register 0 is never forwarded.
  - An EX match on a load is still reported as 01; the stall makes the value unused that cycle.

Test Plan:
- Reset for 2 cycles, then release. Required: S=0 and le_pc=1 for 4 cycles, then S=1; stall_count=0.
- RUN, ex_load_instr=1, ex_rf_enable=1, ex_rd=5, id_uses_rs=1, id_rs=5. Required: one cycle with le_pc=le_npc=le_if_id=0, S=0; stall_count=1. Next cycle (load in MEM): fwd_a=10, no stall.
- ex_rd=3, mem_rd=3, wb_rd=3, all rf_enable=1, id_rs=3, id_rt=0, id_uses_rt=1. Required: fwd_a=01, fwd_b=00.
- id_muldiv_start pulse accepted, then id_reads_hilo held. Required: muldiv_busy=1 for 8 cycles; 8 stall cycles; stall_count=8; S returns to 1 on the 9th cycle.
- Load-use coincides with hilo_haz in the same cycle. Required: exactly one stall cycle counted.
- Reset asserted on the 3rd busy cycle of a mult/div. Required: muldiv_busy=0 and stall_count=0 next cycle, FSM in INIT (S=0 for 4 cycles).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for a 5-stage pipeline: start-up fill, load-use and HI/LO interlocks, EX forwarding selects.
// Latency: enables, S and forwarding selects are combinational; muldiv_busy and stall_count come from registers.
// Backpressure: a stall drops le_pc/le_npc/le_if_id and injects a NOP (S=0) for that cycle.
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int MULDIV_LAT  = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_reads_hilo,
    input  logic                   id_muldiv_start,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_rf_enable,
    input  logic                   ex_load_instr,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_rf_enable,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_rf_enable,
    output logic                   le_pc,
    output logic                   le_npc,
    output logic                   le_if_id,
    output logic                   S,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   muldiv_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int MW = $clog2(MULDIV_LAT + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          init_cnt;
    logic [MW-1:0]          muldiv_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   busy_int;
    logic                   load_use;
    logic                   hilo_haz;
    logic                   stall;
    logic                   accept;

    // State register plus fill counter; the counter only runs while filling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= IW'(INIT_CYCLES - 1);
        end else begin
            state <= state_nxt;
            if (state == ST_INIT && init_cnt != '0)
                init_cnt <= init_cnt - 1'b1;
        end
    end

    // Leave the fill sequence after the cycle in which the counter reads zero.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == '0)
            state_nxt = ST_RUN;
    end

    // Hazard detection; hazards only matter once the pipeline is running.
    always_comb begin
        busy_int = (muldiv_cnt != '0);
        load_use = ex_load_instr && ex_rf_enable && (ex_rd != 5'd0) &&
                   ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        hilo_haz = busy_int && (id_reads_hilo || id_muldiv_start);
        stall    = (state == ST_RUN) && (load_use || hilo_haz);
        accept   = (state == ST_RUN) && !stall && id_muldiv_start;
    end

    // Pipeline enables and control-mux select; everything is held low during reset.
    always_comb begin
        le_pc    = 1'b0;
        le_npc   = 1'b0;
        le_if_id = 1'b0;
        S        = 1'b0;
        if (!reset) begin
            case (state)
                ST_INIT: begin
                    le_pc    = 1'b1;
                    le_npc   = 1'b1;
                    le_if_id = 1'b1;
                end
                default: begin
                    le_pc    = !stall;
                    le_npc   = !stall;
                    le_if_id = !stall;
                    S        = !stall;
                end
            endcase
        end
    end

    // Nearest producer wins: EX, then MEM, then WB; r0 always reads the register file.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        if (r == 5'd0)                        return 2'b00;
        else if (ex_rf_enable  && ex_rd  == r) return 2'b01;
        else if (mem_rf_enable && mem_rd == r) return 2'b10;
        else if (wb_rf_enable  && wb_rd  == r) return 2'b11;
        else                                   return 2'b00;
    endfunction

    // Operand forwarding selects.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!reset) begin
            fwd_a = fwd_sel(id_rs);
            fwd_b = fwd_sel(id_rt);
        end
    end

    // HI/LO busy countdown: reload on an accepted mult/div, otherwise drain to zero.
    always_ff @(posedge clk) begin
        if (reset)
            muldiv_cnt <= '0;
        else if (accept)
            muldiv_cnt <= MW'(MULDIV_LAT);
        else if (muldiv_cnt != '0)
            muldiv_cnt <= muldiv_cnt - 1'b1;
    end

    // Saturating count of RUN-state stall cycles.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    // Registered status outputs, forced to zero while reset is asserted.
    always_comb begin
        muldiv_busy = !reset && busy_int;
        stall_count = reset ? '0 : stall_cnt;
    end

endmodule
